// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I sequencing FSM: steps each instruction through a state sequence
// that drives the shared ALU, the memory port and the PC/IR/register-file enables.
module multicycle_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state_o
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t stateQ;
    state_t stateNext;
    logic   pcUpdate;
    logic   branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= FETCH;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next state and Moore controls; reset overrides every control except ImmSrc.
    always_comb begin
        stateNext = FETCH;
        pcUpdate  = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        illegal   = 1'b0;

        unique case (stateQ)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pcUpdate  = mem_ready;
                stateNext = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_R:         stateNext = EXECUTER;
                    OP_I:         stateNext = EXECUTEI;
                    OP_JAL:       stateNext = JAL;
                    OP_BEQ:       stateNext = BEQ;
                    default:      stateNext = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                stateNext = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                stateNext = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                stateNext = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b10;
                stateNext = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUOp     = 2'b10;
                stateNext = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
            end
            JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pcUpdate  = 1'b1;
                stateNext = ALUWB;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            TRAP: begin
                illegal   = 1'b1;
                stateNext = TRAP;
            end
            default: stateNext = FETCH;
        endcase

        PCWrite = pcUpdate | (branch & zero);
        state_o = stateQ;

        if (!reset_n) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 2'b00;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ALUOp     = 2'b00;
            illegal   = 1'b0;
            state_o   = 4'd0;
        end
    end

    // Immediate format follows the opcode directly, independent of state and reset.
    always_comb begin
        unique case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule
